int_alu_sequencer: RTL and testbench

Execute-side front end for the integer ALU. Accepts one integer operation at a time from the execution engine over a valid/ready handshake and sequences the ALU bus in three bus phases: operand write, compute/read, result capture. Returns a 64-bit result plus error flag over a valid/ready response handshake. Screens illegal opcodes and divide-by-zero so the ALU is never driven with them.

---
 rtl/int_alu_sequencer_pkg.sv | 24 ++
 rtl/int_alu_sequencer_if.sv | 45 ++++
 rtl/int_alu_sequencer.sv | 82 ++++++++
 tb/tb_int_alu_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/int_alu_sequencer_pkg.sv
// Shared definitions for the integer ALU sequencer: opcodes, ALU select value
// and the sequencer state type.
package int_alu_pkg;

    localparam logic [7:0] INT_ADD  = 8'h10;
    localparam logic [7:0] INT_SUB  = 8'h11;
    localparam logic [7:0] INT_MULT = 8'h12;
    localparam logic [7:0] INT_DIV  = 8'h13;

    localparam logic [3:0] INT_ALU_SEL = 4'h5;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        RESP
    } seq_state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op >= INT_ADD) && (op <= INT_DIV);
    endfunction

endpackage

// File: rtl/int_alu_sequencer_if.sv
// Execution-engine request/response handshake and integer ALU bus bundles.
interface int_alu_exe_if #(
    parameter int unsigned OPND_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_opcode;
    logic [OPND_W-1:0] req_a;
    logic [OPND_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OPND_W-1:0] rsp_data;
    logic              rsp_err;

    // master = execution engine, slave = sequencer
    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

interface int_alu_bus_if #(
    parameter int unsigned BUS_W = 256
);
    logic [15:0]      address;
    logic [7:0]       opcode;
    logic [BUS_W-1:0] ExeDataOut;
    logic             nWrite;
    logic             nRead;
    logic [BUS_W-1:0] IntDataOut;

    // master = sequencer, slave = integer ALU
    modport master (
        output address, opcode, ExeDataOut, nWrite, nRead,
        input  IntDataOut
    );
    modport slave (
        input  address, opcode, ExeDataOut, nWrite, nRead,
        output IntDataOut
    );
endinterface

// File: rtl/int_alu_sequencer.sv
// Integer ALU front end: accepts one op, runs the write/read/capture bus
// phases and returns the result; illegal ops and divide-by-zero never reach the ALU.
module int_alu_sequencer #(
    parameter logic [3:0]  INT_ALU_SEL = int_alu_pkg::INT_ALU_SEL,
    parameter int unsigned OPND_W      = 64,
    parameter int unsigned BUS_W       = 256
) (
    input logic           Clk,
    input logic           Reset,
    int_alu_exe_if.slave  exe,
    int_alu_bus_if.master alu
);
    import int_alu_pkg::*;

    seq_state_t state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            exe.req_ready  <= 1'b1;
            exe.rsp_valid  <= 1'b0;
            exe.rsp_data   <= '0;
            exe.rsp_err    <= 1'b0;
            alu.address    <= '0;
            alu.opcode     <= '0;
            alu.ExeDataOut <= '0;
            alu.nWrite     <= 1'b1;
            alu.nRead      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (exe.req_valid) begin
                        exe.req_ready <= 1'b0;
                        // Screened requests skip the bus entirely and answer next cycle
                        if (!is_legal_op(exe.req_opcode)) begin
                            state         <= RESP;
                            exe.rsp_valid <= 1'b1;
                            exe.rsp_err   <= 1'b1;
                            exe.rsp_data  <= '0;
                        end else if (exe.req_opcode == INT_DIV && exe.req_b == '0) begin
                            state         <= RESP;
                            exe.rsp_valid <= 1'b1;
                            exe.rsp_err   <= 1'b1;
                            exe.rsp_data  <= '1;
                        end else begin
                            state          <= WRITE;
                            alu.address    <= {INT_ALU_SEL, 12'h000};
                            alu.opcode     <= exe.req_opcode;
                            alu.ExeDataOut <= {{(BUS_W-2*OPND_W){1'b0}}, exe.req_b, exe.req_a};
                            alu.nWrite     <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    state      <= READ;
                    alu.nWrite <= 1'b1;
                    alu.nRead  <= 1'b0;
                end
                READ: begin
                    state     <= CAPTURE;
                    alu.nRead <= 1'b1;
                end
                CAPTURE: begin
                    state         <= RESP;
                    exe.rsp_data  <= alu.IntDataOut[OPND_W-1:0];
                    exe.rsp_err   <= 1'b0;
                    exe.rsp_valid <= 1'b1;
                    alu.address   <= '0;
                end
                RESP: begin
                    if (exe.rsp_ready) begin
                        state         <= IDLE;
                        exe.rsp_valid <= 1'b0;
                        exe.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_alu_sequencer.sv
// Self-checking bench: sequencer paired with a behavioural integer ALU,
// table-driven ops with a response scoreboard plus reset/backpressure sequences.
module tb_int_alu_sequencer;
    import int_alu_pkg::*;

    logic Clk;
    logic Reset;

    int_alu_exe_if exe_if ();
    int_alu_bus_if bus_if ();

    int_alu_sequencer #(
        .INT_ALU_SEL(4'h5),
        .OPND_W     (64),
        .BUS_W      (256)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .exe  (exe_if.slave),
        .alu  (bus_if.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural integer ALU: latches operands on write, drives result on read
    logic [7:0]  alu_op;
    logic [63:0] alu_a, alu_b;
    always_ff @(posedge Clk) begin
        if (!bus_if.nWrite && bus_if.address[15:12] == 4'h5) begin
            alu_op <= bus_if.opcode;
            alu_a  <= bus_if.ExeDataOut[63:0];
            alu_b  <= bus_if.ExeDataOut[127:64];
        end
        if (!bus_if.nRead) begin
            case (alu_op)
                8'h10:   bus_if.IntDataOut <= {192'h0, alu_a + alu_b};
                8'h11:   bus_if.IntDataOut <= {192'h0, alu_a - alu_b};
                8'h12:   bus_if.IntDataOut <= {192'h0, alu_a * alu_b};
                8'h13:   bus_if.IntDataOut <= {192'h0, alu_a / alu_b};
                default: bus_if.IntDataOut <= '0;
            endcase
        end
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe counters, cleared by the driver at each accept
    int unsigned wr_cnt, rd_cnt;
    always @(posedge Clk) begin
        if (!bus_if.nWrite) wr_cnt++;
        if (!bus_if.nRead)  rd_cnt++;
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("strobe overlap", {255'h0, (!bus_if.nWrite && !bus_if.nRead)}, 256'h0);
            if (exe_if.rsp_valid || exe_if.req_ready)
                chk("addr sel idle", {255'h0, (bus_if.address[15:12] == 4'h5)}, 256'h0);
        end
    end

    typedef struct {
        logic [63:0] data;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    typedef struct {
        logic [7:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_data;
        logic        exp_err;
        int unsigned hold;
    } vec_t;
    vec_t vecs[9];

    task automatic check_reset_vals(input string tag);
        chk({tag, " req_ready"},  {255'h0, exe_if.req_ready}, 256'h1);
        chk({tag, " rsp_valid"},  {255'h0, exe_if.rsp_valid}, 256'h0);
        chk({tag, " rsp_data"},   {192'h0, exe_if.rsp_data},  256'h0);
        chk({tag, " rsp_err"},    {255'h0, exe_if.rsp_err},   256'h0);
        chk({tag, " address"},    {240'h0, bus_if.address},   256'h0);
        chk({tag, " opcode"},     {248'h0, bus_if.opcode},    256'h0);
        chk({tag, " ExeDataOut"}, bus_if.ExeDataOut,          256'h0);
        chk({tag, " nWrite"},     {255'h0, bus_if.nWrite},    256'h1);
        chk({tag, " nRead"},      {255'h0, bus_if.nRead},     256'h1);
    endtask

    task automatic do_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_data, input logic exp_err, input int unsigned hold);
        int unsigned n;
        rsp_t        e;
        logic [63:0] d0;
        n = 0;
        while (!exe_if.req_ready && n < 20) begin
            @(posedge Clk); #1; n++;
        end
        chk("req_ready before accept", {255'h0, exe_if.req_ready}, 256'h1);
        exe_if.req_valid  = 1'b1;
        exe_if.req_opcode = op;
        exe_if.req_a      = a;
        exe_if.req_b      = b;
        exe_if.rsp_ready  = (hold == 0);
        exp_q.push_back('{data: exp_data, err: exp_err});
        @(posedge Clk); #1;
        exe_if.req_valid = 1'b0;
        wr_cnt = 0;
        rd_cnt = 0;
        chk("req_ready after accept", {255'h0, exe_if.req_ready}, 256'h0);
        n = 1;
        while (!exe_if.rsp_valid && n < 12) begin
            @(posedge Clk); #1; n++;
        end
        chk("rsp latency", {224'h0, n}, exp_err ? 256'd1 : 256'd4);
        if (!exe_if.rsp_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        chk("rsp_data", {192'h0, exe_if.rsp_data}, {192'h0, e.data});
        chk("rsp_err",  {255'h0, exe_if.rsp_err},  {255'h0, e.err});
        chk("nWrite pulses", {224'h0, wr_cnt}, exp_err ? 256'd0 : 256'd1);
        chk("nRead pulses",  {224'h0, rd_cnt}, exp_err ? 256'd0 : 256'd1);
        d0 = exe_if.rsp_data;
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            chk("bp rsp_valid", {255'h0, exe_if.rsp_valid}, 256'h1);
            chk("bp rsp_data",  {192'h0, exe_if.rsp_data}, {192'h0, d0});
            chk("bp req_ready", {255'h0, exe_if.req_ready}, 256'h0);
        end
        exe_if.rsp_ready = 1'b1;
        @(posedge Clk); #1;
        exe_if.rsp_ready = 1'b0;
        chk("rsp_valid after consume", {255'h0, exe_if.rsp_valid}, 256'h0);
        chk("req_ready after consume", {255'h0, exe_if.req_ready}, 256'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        vecs[0] = '{op: INT_ADD,  a: 64'd5,          b: 64'd7,          exp_data: 64'd12,   exp_err: 1'b0, hold: 0};
        vecs[1] = '{op: INT_SUB,  a: 64'd0,          b: 64'd1,          exp_data: '1,       exp_err: 1'b0, hold: 0};
        vecs[2] = '{op: INT_MULT, a: 64'h1_0000_0000, b: 64'h1_0000_0000, exp_data: 64'd0,  exp_err: 1'b0, hold: 0};
        vecs[3] = '{op: INT_DIV,  a: 64'd100,        b: 64'd7,          exp_data: 64'd14,   exp_err: 1'b0, hold: 0};
        vecs[4] = '{op: INT_DIV,  a: 64'd9,          b: 64'd0,          exp_data: '1,       exp_err: 1'b1, hold: 0};
        vecs[5] = '{op: 8'h20,    a: 64'd3,          b: 64'd4,          exp_data: 64'd0,    exp_err: 1'b1, hold: 0};
        vecs[6] = '{op: INT_ADD,  a: 64'd1,          b: 64'd1,          exp_data: 64'd2,    exp_err: 1'b0, hold: 0};
        vecs[7] = '{op: INT_MULT, a: 64'd3,          b: 64'd5,          exp_data: 64'd15,   exp_err: 1'b0, hold: 5};
        vecs[8] = '{op: 8'h0F,    a: 64'd1,          b: 64'd2,          exp_data: 64'd0,    exp_err: 1'b1, hold: 2};

        exe_if.req_valid  = 1'b0;
        exe_if.req_opcode = '0;
        exe_if.req_a      = '0;
        exe_if.req_b      = '0;
        exe_if.rsp_ready  = 1'b0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_vals("reset");
        Reset = 1'b0;
        @(posedge Clk); #1;

        for (int unsigned i = 0; i < 9; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_err, vecs[i].hold);

        // Reset while the sequencer is in READ aborts the op silently
        exe_if.req_valid  = 1'b1;
        exe_if.req_opcode = INT_ADD;
        exe_if.req_a      = 64'd50;
        exe_if.req_b      = 64'd60;
        exe_if.rsp_ready  = 1'b1;
        @(posedge Clk); #1;
        exe_if.req_valid = 1'b0;
        @(posedge Clk); #1;
        chk("in READ nRead", {255'h0, bus_if.nRead}, 256'h0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check_reset_vals("mid reset");
        n = 0;
        repeat (4) begin
            @(posedge Clk); #1;
            if (exe_if.rsp_valid) n++;
        end
        chk("no rsp after abort", {224'h0, n}, 256'h0);
        exe_if.rsp_ready = 1'b0;
        do_op(INT_ADD, 64'd3, 64'd4, 64'd7, 1'b0, 0);

        chk("scoreboard empty", {224'h0, exp_q.size()}, 256'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
